// File: rtl/i2c_pkg.sv
// I2C shared definitions: FSM states, bus
// bit values and byte geometry.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int I2C_BITS = 8;
  localparam logic [2:0] I2C_MSB = 3'(I2C_BITS - 1);

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with a registered
// previous value for rise/fall detection.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Idle I2C bus is high, so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address, byte write
// into rx_data, byte read from tx_data.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_underrun
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       sda_oe;
  logic [7:0] rd_byte;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start   = sda_fall & scl_lvl;
  assign stop    = sda_rise & scl_lvl;
  assign rd_byte = tx_valid ? tx_data : 8'hFF;
  assign sda     = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= I2C_MSB;
      shreg       <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= I2C_MSB;
        sda_oe  <= 1'b0;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_lvl};
            if (bit_cnt == 3'd0) begin
              if (shreg[6:0] == DEV_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= sda_lvl;
              end else begin
                state <= WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          // First fall pulls ACK low, second releases
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= I2C_MSB;
              if (state == WR_ACK || !rw) begin
                state <= WR_DATA;
              end else begin
                state       <= RD_DATA;
                shreg       <= rd_byte;
                sda_oe      <= ~rd_byte[7];
                tx_ready    <= tx_valid;
                tx_underrun <= ~tx_valid;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_lvl};
            if (bit_cnt == 3'd0) begin
              rx_data  <= {shreg[6:0], sda_lvl};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              shreg   <= {shreg[6:0], 1'b1};
              sda_oe  <= ~shreg[6];
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_lvl == I2C_NACK) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              state       <= RD_DATA;
              bit_cnt     <= I2C_MSB;
              shreg       <= rd_byte;
              sda_oe      <= ~rd_byte[7];
              tx_ready    <= tx_valid;
              tx_underrun <= ~tx_valid;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target driving a
// bit-banged I2C controller on a pulled-up bus.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 40;
  localparam logic [1:0] EV_RX  = 2'd0;
  localparam logic [1:0] EV_TXR = 2'd1;
  localparam logic [1:0] EV_UND = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b0;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       tx_underrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int drove_cnt = 0;
  logic [9:0] exp_q[$];

  pullup (sda);
  assign sda = sda_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic observe(input logic [9:0] got);
    logic [9:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %0h expected none",
               got);
    end else begin
      e = exp_q.pop_front();
      if (e === got) pass_cnt++;
      else $display("FAIL event: got %0h expected %0h", got, e);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid)    observe({EV_RX, rx_data});
    if (tx_ready)    observe({EV_TXR, tx_data});
    if (tx_underrun) observe({EV_UND, 8'hFF});
    if (!sda_drv && sda === 1'b0) drove_cnt++;
  end

  task automatic clock_bit(input logic b, output logic r);
    sda_drv = ~b;
    #Q scl = 1'b1;
    #Q r = sda;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b,
                            output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_bits(input int n,
                           output logic [7:0] d);
    logic r;
    d = 8'h00;
    repeat (n) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
  endtask

  task automatic do_start();
    if (!scl) begin
      sda_drv = 1'b0;
      #Q scl = 1'b1;
      #Q;
    end
    sda_drv = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic do_stop();
    sda_drv = 1'b1;
    #Q scl = 1'b1;
    #Q sda_drv = 1'b0;
    #(3 * Q);
  endtask

  initial begin
    logic a;
    logic r;
    logic [7:0] d;
    int base;
    int ones;

    #25;
    check("reset_outputs",
          {sda, busy, rx_valid, tx_ready, tx_underrun, rx_data},
          {1'b1, 4'b0000, 8'h00});
    rst_n = 1'b1;
    #100;

    // Plain write of 0xA5
    exp_q.push_back({EV_RX, 8'hA5});
    do_start();
    write_byte(8'h84, a);
    check("wr_addr_ack", a, I2C_ACK);
    check("wr_busy", busy, 1'b1);
    write_byte(8'hA5, a);
    check("wr_data_ack", a, I2C_ACK);
    do_stop();
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_busy_stop", busy, 1'b0);

    // Wrong address
    base = drove_cnt;
    do_start();
    write_byte(8'h86, a);
    check("miss_addr_nack", a, I2C_NACK);
    check("miss_busy", busy, 1'b0);
    write_byte(8'hA5, a);
    check("miss_data_nack", a, I2C_NACK);
    do_stop();
    check("miss_busy_stop", busy, 1'b0);
    check("miss_sda_driven", drove_cnt - base, 0);

    // Read: valid byte, then underrun
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back({EV_TXR, 8'h3C});
    exp_q.push_back({EV_UND, 8'hFF});
    do_start();
    write_byte(8'h85, a);
    check("rd_addr_ack", a, I2C_ACK);
    read_bits(8, d);
    check("rd_byte0", d, 8'h3C);
    tx_valid = 1'b0;
    clock_bit(I2C_ACK, r);
    read_bits(8, d);
    check("rd_byte1", d, 8'hFF);
    clock_bit(I2C_NACK, r);
    check("rd_wait_stop", dut.state, WAIT_STOP);
    check("rd_busy", busy, 1'b1);
    do_stop();
    check("rd_busy_stop", busy, 1'b0);

    // Partial write then repeated START read
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    exp_q.push_back({EV_TXR, 8'h5A});
    do_start();
    write_byte(8'h84, a);
    check("rs_wr_ack", a, I2C_ACK);
    for (int i = 0; i < 4; i++) clock_bit(i[0], r);
    do_start();
    write_byte(8'h85, a);
    check("rs_rd_ack", a, I2C_ACK);
    read_bits(8, d);
    check("rs_rd_byte", d, 8'h5A);
    clock_bit(I2C_NACK, r);
    do_stop();
    check("rs_busy_stop", busy, 1'b0);
    tx_valid = 1'b0;

    // Reset while the ACK is held low
    do_start();
    d = 8'h84;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    sda_drv = 1'b0;
    #(2 * Q);
    check("rst_ack_low", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_release", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    #29 rst_n = 1'b1;
    #Q;
    write_byte(8'h84, a);
    check("rst_ignored_nack", a, I2C_NACK);
    check("rst_ignored_busy", busy, 1'b0);
    do_stop();
    exp_q.push_back({EV_RX, 8'hA5});
    do_start();
    write_byte(8'h84, a);
    check("rst_new_addr_ack", a, I2C_ACK);
    write_byte(8'hA5, a);
    check("rst_new_data_ack", a, I2C_ACK);
    do_stop();
    check("rst_new_rx_data", rx_data, 8'hA5);

    // STOP in the middle of a read byte
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back({EV_TXR, 8'h3C});
    do_start();
    write_byte(8'h85, a);
    check("mid_addr_ack", a, I2C_ACK);
    read_bits(2, d);
    check("mid_first_bits", d, 8'h00);
    do_stop();
    check("mid_state_idle", dut.state, IDLE);
    check("mid_busy", busy, 1'b0);
    ones = 0;
    repeat (6) begin
      scl = 1'b0;
      #(2 * Q);
      if (sda === 1'b1) ones++;
      scl = 1'b1;
      #(2 * Q);
    end
    check("mid_sda_released", ones, 6);
    tx_valid = 1'b0;

    #200;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h42, the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on scl and sda (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, at least 8x the scl frequency.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl, input, 1 bit: I2C clock from the controller; the target never stretches it.
REQ-006 The block SHALL have port sda, inout, 1 bit: I2C data, open-drain; the block drives only 1'b0 or 1'bz.
REQ-007 The block SHALL have port rx_data, output, 8 bits: the last byte written by the controller.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-009 The block SHALL have port tx_data, input, 8 bits: the byte to return on a read.
REQ-010 The block SHALL have port tx_valid, input, 1 bit: tx_data holds a valid byte.
REQ-011 The block SHALL have port tx_ready, output, 1 bit: one-clk pulse when tx_data is latched for shifting.
REQ-012 The block SHALL have port busy, output, 1 bit: high from an address match until STOP.
REQ-013 The block SHALL have port tx_underrun, output, 1 bit: one-clk pulse when a read byte is needed while tx_valid=0.

Function
REQ-014 scl and sda SHALL each pass through SYNC_STAGES flops, followed by one edge-detect register.
REQ-015 START SHALL be detected as a synchronized sda fall while synchronized scl=1; STOP SHALL be detected as an sda rise while scl=1.
REQ-016 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-017 A START in any state (including a repeated START) SHALL clear the bit counter, release sda, and enter ADDR.
REQ-018 A STOP in any state SHALL release sda, deassert busy, and enter IDLE.
REQ-019 Inbound bits SHALL be sampled on the scl rising edge, MSB first; sda SHALL change only on scl falling edges.
REQ-020 ADDR SHALL shift 8 bits (7-bit address plus R/W); on a match it SHALL enter ADDR_ACK and assert busy; on a mismatch it SHALL enter WAIT_STOP with sda released.
REQ-021 On a match, sda SHALL be pulled low from the falling edge after bit 8 until the following falling edge (the ACK clock).
REQ-022 At that release falling edge: if R/W=0, the FSM SHALL enter WR_DATA; if R/W=1, it SHALL enter RD_DATA, latch the tx byte, and drive its MSB.
REQ-023 WR_DATA SHALL shift 8 bits, then update rx_data and pulse rx_valid in the clk after the 8th scl rise, then ACK (WR_ACK) and return to WR_DATA.
REQ-024 The read byte SHALL be tx_data if tx_valid=1 (pulse tx_ready); otherwise it SHALL be 8'hFF and tx_underrun SHALL pulse.
REQ-025 A read bit of 1 SHALL release sda (z); a read bit of 0 SHALL drive 0.
REQ-026 After 8 read bits, sda SHALL be released and RD_ACK SHALL sample the controller's bit on the scl rise: 0 reloads and continues RD_DATA, 1 enters WAIT_STOP.
REQ-027 A bit counter SHALL count 7 down to 0; the 9th clock SHALL be handled by the ACK states only.
REQ-028 Simultaneous START/STOP detect and bit sample SHALL give START/STOP priority; the partial byte SHALL be discarded with no rx_valid.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, sda=z, rx_data=8'h00, and rx_valid=tx_ready=tx_underrun=busy=0.
REQ-030 A reset mid-transfer SHALL release sda in the same cycle (asynchronously); after reset, the block SHALL ignore bus activity until the next START.

Structure
REQ-031 Package i2c_pkg SHALL hold the FSM state enum, I2C_ACK=1'b0, I2C_NACK=1'b1, and the bits-per-byte constant 8; it is shared with the controller.
REQ-032 Sub-module i2c_sync_edge SHALL implement the synchronizer plus rise/fall detect; it is instantiated once each for scl and sda.

Verification
REQ-033 Write 0x84 (addr 0x42, W), then 0xA5 -> ACK on both 9th clocks; rx_data=0xA5 with one rx_valid pulse; busy falls at STOP.
REQ-034 Address 0x43, W -> sda never driven; NACK seen; no rx_valid; busy stays 0.
REQ-035 Read 0x85 with tx_data=0x3C, tx_valid=1, then controller ACK, then NACK with tx_valid=0 -> bytes 0x3C then 0xFF; one tx_ready, one tx_underrun; WAIT_STOP.
REQ-036 Write 0x84, 4 bits, then repeated START with 0x85 -> partial byte dropped; read phase proceeds normally.
REQ-037 Assert rst_n=0 while the target drives an ACK low -> sda=z immediately; post-reset bus traffic ignored until a START.
REQ-038 STOP in the middle of a read byte -> sda released the same clk as STOP detect; state=IDLE.
